// File: rtl/minesweeper_board_cover_pkg.sv
// Shared minesweeper definitions: cell cover encoding, default grid geometry,
// and the per-cycle transition record handed to the counter block.
package minesweeper_board_cover_pkg;

    localparam int unsigned X_SIZE_DEF       = 16;
    localparam int unsigned Y_SIZE_DEF       = 16;
    localparam int unsigned X_COORD_BITS_DEF = 4;
    localparam int unsigned Y_COORD_BITS_DEF = 4;

    typedef enum logic [1:0] {
        COVERED = 2'b00,
        FLAGGED = 2'b01,
        OPEN    = 2'b10
    } cell_t;

    typedef struct packed {
        logic set_flag;
        logic clr_flag;
        logic set_open;
    } cover_evt_t;

endpackage

// File: rtl/minesweeper_board_cover_cnt.sv
// Flag / open tallies driven by the board's per-cycle cell transition events.
module board_cover_cnt
    import minesweeper_board_cover_pkg::*;
#(
    parameter int unsigned cnt_bits = 9,
    parameter int unsigned cnt_max  = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  cover_evt_t          evt,
    output logic [cnt_bits-1:0] num_flags,
    output logic [cnt_bits-1:0] num_open
);

    localparam logic [cnt_bits-1:0] MAX = cnt_bits'(cnt_max);

    // Bounds guards keep a corrupted event stream from wrapping either count.
    always_ff @(posedge clk) begin
        if (reset) begin
            num_flags <= '0;
            num_open  <= '0;
        end else begin
            if (evt.set_flag && num_flags != MAX)
                num_flags <= num_flags + 1'b1;
            else if (evt.clr_flag && num_flags != '0)
                num_flags <= num_flags - 1'b1;
            if (evt.set_open && num_open != MAX)
                num_open <= num_open + 1'b1;
        end
    end

endmodule

// File: rtl/minesweeper_board_cover.sv
// Per-cell cover/flag/open store addressed by the cursor.
// Optional BOARD_COVER_COUNT_EN adds flagged/opened cell counters.
module minesweeper_board_cover
    import minesweeper_board_cover_pkg::*;
#(
    parameter int unsigned x_size       = X_SIZE_DEF,
    parameter int unsigned y_size       = Y_SIZE_DEF,
    parameter int unsigned x_coord_bits = X_COORD_BITS_DEF,
    parameter int unsigned y_coord_bits = Y_COORD_BITS_DEF
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flag,
    input  logic                                open,
    input  logic [x_coord_bits-1:0]             x_coord,
    input  logic [y_coord_bits-1:0]             y_coord,
    output logic [1:0]                          cell_val,
    output logic [x_coord_bits+y_coord_bits:0]  num_flags,
    output logic [x_coord_bits+y_coord_bits:0]  num_open
);

    localparam int unsigned NUM_CELLS = x_size * y_size;
    localparam int unsigned IDX_W     = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
    localparam int unsigned CNT_BITS  = x_coord_bits + y_coord_bits + 1;

    cell_t             cells [NUM_CELLS];
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    cell_t             cur;
    cell_t             nxt;
    logic              set_flag;
    logic              clr_flag;
    logic              set_open;
    logic              write;

    // Simultaneous flag+open is treated as no action at all.
    always_comb begin
        in_range = (32'(x_coord) < x_size) && (32'(y_coord) < y_size);
        idx      = IDX_W'(32'(y_coord) * x_size + 32'(x_coord));
        cur      = in_range ? cells[idx] : COVERED;
        set_flag = in_range && flag && !open && (cur == COVERED);
        clr_flag = in_range && flag && !open && (cur == FLAGGED);
        set_open = in_range && open && !flag && (cur == COVERED);
        write    = set_flag || clr_flag || set_open;
        nxt      = set_flag ? FLAGGED : (set_open ? OPEN : COVERED);
    end

    assign cell_val = cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CELLS; i++)
                cells[i] <= COVERED;
        end else if (write) begin
            cells[idx] <= nxt;
        end
    end

`ifdef BOARD_COVER_COUNT_EN
    cover_evt_t evt;

    assign evt = '{set_flag: set_flag, clr_flag: clr_flag, set_open: set_open};

    board_cover_cnt #(
        .cnt_bits (CNT_BITS),
        .cnt_max  (NUM_CELLS)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .evt       (evt),
        .num_flags (num_flags),
        .num_open  (num_open)
    );
`else
    assign num_flags = '0;
    assign num_open  = '0;
`endif

endmodule

// File: tb/tb_minesweeper_board_cover.sv
// Self-checking bench for minesweeper_board_cover: directed vector table,
// corner sequences and a random stream checked against a behavioural model.
module tb_minesweeper_board_cover;

`ifdef BOARD_COVER_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flag = 1'b0;
    logic       open = 1'b0;
    logic [3:0] x_coord = '0;
    logic [3:0] y_coord = '0;
    logic [1:0] cell_val;
    logic [8:0] num_flags;
    logic [8:0] num_open;

    always #5 clk = ~clk;

    minesweeper_board_cover dut (
        .clk       (clk),
        .reset     (reset),
        .flag      (flag),
        .open      (open),
        .x_coord   (x_coord),
        .y_coord   (y_coord),
        .cell_val  (cell_val),
        .num_flags (num_flags),
        .num_open  (num_open)
    );

    typedef struct {
        logic [1:0] c;
        int         nf;
        int         no;
    } exp_t;

    typedef struct {
        int         x;
        int         y;
        bit         f;
        bit         o;
        bit         r;
        logic [1:0] c;
        int         nf;
        int         no;
    } vec_t;

    exp_t sbq[$];
    int   compared = 0;
    int   mismatched = 0;
    int   mcell[256];
    int   mnf = 0;
    int   mno = 0;

    // Model applies the inputs that were held across the edge just passed.
    function automatic void model_step();
        int i;
        i = int'(y_coord) * 16 + int'(x_coord);
        if (reset) begin
            for (int k = 0; k < 256; k++) mcell[k] = 0;
            mnf = 0;
            mno = 0;
        end else if (flag && !open) begin
            if (mcell[i] == 0) begin mcell[i] = 1; mnf++; end
            else if (mcell[i] == 1) begin mcell[i] = 0; mnf--; end
        end else if (open && !flag) begin
            if (mcell[i] == 0) begin mcell[i] = 2; mno++; end
        end
    endfunction

    function automatic exp_t mexp();
        exp_t e;
        e.c  = 2'(mcell[int'(y_coord) * 16 + int'(x_coord)]);
        e.nf = COUNT_EN ? mnf : 0;
        e.no = COUNT_EN ? mno : 0;
        return e;
    endfunction

    function automatic exp_t cexp(input logic [1:0] c, input int nf, input int no);
        exp_t e;
        e.c  = c;
        e.nf = COUNT_EN ? nf : 0;
        e.no = COUNT_EN ? no : 0;
        return e;
    endfunction

    task automatic apply(input int x, input int y, input bit f, input bit o, input bit r);
        @(negedge clk);
        model_step();
        x_coord = 4'(x);
        y_coord = 4'(y);
        flag    = f;
        open    = o;
        reset   = r;
    endtask

    task automatic check(input string name);
        exp_t e;
        #1;
        e = sbq.pop_front();
        compared++;
        if (cell_val !== e.c) begin
            mismatched++;
            $display("FAIL %s cell_val at (%0d,%0d): got %0d want %0d", name, x_coord, y_coord, cell_val, e.c);
        end
        compared++;
        if ($isunknown(num_flags) || int'(num_flags) != e.nf) begin
            mismatched++;
            $display("FAIL %s num_flags: got %0d want %0d", name, num_flags, e.nf);
        end
        compared++;
        if ($isunknown(num_open) || int'(num_open) != e.no) begin
            mismatched++;
            $display("FAIL %s num_open: got %0d want %0d", name, num_open, e.no);
        end
    endtask

    vec_t vt[16];

    initial begin
        vt[0]  = '{3, 5, 1, 0, 0, 2'd1, 1, 0};
        vt[1]  = '{3, 5, 1, 0, 0, 2'd0, 0, 0};
        vt[2]  = '{3, 5, 1, 0, 0, 2'd1, 1, 0};
        vt[3]  = '{3, 5, 0, 1, 0, 2'd1, 1, 0};
        vt[4]  = '{3, 5, 1, 0, 0, 2'd0, 0, 0};
        vt[5]  = '{3, 5, 0, 1, 0, 2'd2, 0, 1};
        vt[6]  = '{3, 5, 1, 0, 0, 2'd2, 0, 1};
        vt[7]  = '{0, 0, 1, 1, 0, 2'd0, 0, 1};
        vt[8]  = '{15, 15, 0, 1, 0, 2'd2, 0, 2};
        vt[9]  = '{0, 15, 1, 0, 0, 2'd1, 1, 2};
        vt[10] = '{1, 1, 0, 1, 1, 2'd0, 0, 0};
        vt[11] = '{15, 15, 0, 0, 0, 2'd0, 0, 0};
        vt[12] = '{0, 15, 0, 0, 0, 2'd0, 0, 0};
        vt[13] = '{3, 5, 0, 0, 0, 2'd0, 0, 0};
        vt[14] = '{0, 0, 0, 1, 0, 2'd2, 0, 1};
        vt[15] = '{7, 7, 0, 0, 0, 2'd0, 0, 1};

        repeat (3) @(posedge clk);

        // Post-reset sweep of every coordinate
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) begin
                apply(x, y, 0, 0, 0);
                sbq.push_back(cexp(2'd0, 0, 0));
                check("reset_sweep");
            end

        // Directed vectors: strobe cycle, then observe in the following cycle
        for (int i = 0; i < 16; i++) begin
            apply(vt[i].x, vt[i].y, vt[i].f, vt[i].o, vt[i].r);
            apply(vt[i].x, vt[i].y, 0, 0, 0);
            sbq.push_back(cexp(vt[i].c, vt[i].nf, vt[i].no));
            check($sformatf("vec%0d", i));
        end

        // Cursor move is visible without a clock edge
        apply(0, 0, 0, 0, 0);
        sbq.push_back(cexp(2'd2, 0, 1));
        check("cursor_00");
        #2;
        x_coord = 4'd7;
        y_coord = 4'd7;
        sbq.push_back(cexp(2'd0, 0, 1));
        check("cursor_77_same_cycle");

        // Flag held two cycles acts twice
        apply(2, 2, 1, 0, 0);
        sbq.push_back(cexp(2'd0, 0, 1));
        check("held_flag_c0");
        apply(2, 2, 1, 0, 0);
        sbq.push_back(cexp(2'd1, 1, 1));
        check("held_flag_c1");
        apply(2, 2, 0, 0, 0);
        sbq.push_back(cexp(2'd0, 0, 1));
        check("held_flag_done");

        // Flag every cell, counter reaches full-grid value
        apply(0, 0, 0, 0, 1);
        for (int i = 0; i < 256; i++) apply(i % 16, i / 16, 1, 0, 0);
        apply(9, 4, 0, 0, 0);
        sbq.push_back(cexp(2'd1, 256, 0));
        check("all_flagged");
        apply(9, 4, 0, 1, 0);
        apply(9, 4, 0, 0, 0);
        sbq.push_back(cexp(2'd1, 256, 0));
        check("open_on_flag_full");

        // Random stream against the model
        for (int n = 0; n < 600; n++) begin
            apply($urandom_range(0, 15), $urandom_range(0, 15),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 99) == 0));
            sbq.push_back(mexp());
            check("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/minesweeper_board_cover.md
# minesweeper_board_cover

Per-cell cover state store for the minesweeper game: a `x_size` × `y_size` grid holding, for each cell, whether it is covered, flagged, or opened. It sits beside the mine/number board in the game top level. It consumes single-cycle `flag`/`open` action strobes aimed at the cursor (`x_coord`, `y_coord`) and presents the cursor cell's cover state to the display path.

## Interface
Parameters:
- `x_size`, default 16: grid width in cells.
- `y_size`, default 16: grid height in cells.
- `x_coord_bits`, default 4: width of `x_coord`.
- `y_coord_bits`, default 4: width of `y_coord`.

Ports:
- `clk`  in  1: single system clock; all state is updated on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `flag`  in  1: one-cycle strobe that toggles the flag on the cursor cell.
- `open`  in  1: one-cycle strobe that opens the cursor cell.
- `x_coord`  in  `x_coord_bits`: cursor column.
- `y_coord`  in  `y_coord_bits`: cursor row.
- `cell_val`  out  2: cover state of the cursor cell.
- `num_flags`  out  `x_coord_bits+y_coord_bits+1`: number of flagged cells.
- `num_open`  out  `x_coord_bits+y_coord_bits+1`: number of opened cells.

## Operation
- Cell encoding:
  - 2'b00 COVERED
  - 2'b01 FLAGGED
  - 2'b10 OPEN
  - 2'b11 is never stored.
- Reset: every cell is set to COVERED. `num_flags` = 0, `num_open` = 0.
- Per-cell transitions, applied to the cursor cell only:
  - `flag` on COVERED → FLAGGED.
  - `flag` on FLAGGED → COVERED.
  - `flag` on OPEN → no change.
  - `open` on COVERED → OPEN.
  - `open` on FLAGGED → no change (flag protects the cell).
  - `open` on OPEN → no change.
- `flag` and `open` asserted in the same cycle: no change to any cell or counter.
- Cursor out of range (`x_coord >= x_size` or `y_coord >= y_size`):
  - Strobes are ignored.
  - `cell_val` reads 2'b00.
- Counters:
  - `num_flags` increments on COVERED→FLAGGED and decrements on FLAGGED→COVERED.
  - `num_open` increments on COVERED→OPEN.
  - Counters never wrap; their maximum is `x_size*y_size`.
- Strobes are level-sampled every cycle. A strobe held for N cycles acts N times; for example, `flag` held for 2 cycles restores COVERED.

## Timing
- `cell_val` is a combinational read of the stored state at the current coordinates.
  - A coordinate change is visible in the same cycle.
- A cell update caused by a strobe in cycle N is visible on `cell_val` and on the counters from cycle N+1.
- `reset` takes priority over `flag` and `open` in the same cycle.
- A reset asserted mid-game clears the whole grid at that edge.
- No handshake: strobes are fire-and-forget.

## Configuration
- `BOARD_COVER_COUNT_EN` defined: `num_flags` and `num_open` are maintained as described in Operation.
- `BOARD_COVER_COUNT_EN` undefined: the counter logic is removed and both outputs are tied to 0. Cell behaviour is otherwise identical.

## Structure
- Shared game package holds:
  - the cell encoding constants COVERED, FLAGGED and OPEN;
  - the default grid dimensions and coordinate widths.
- Storage is a flat register array of `x_size*y_size` 2-bit entries, indexed by `y_coord*x_size + x_coord`.
- One sub-module is natural: `board_cover_cnt`.
  - It holds the two saturating-safe up/down counters.
  - It is driven by per-cycle transition flags.
  - It is instantiated only under `BOARD_COVER_COUNT_EN`.

## Test plan
- Reset, then read all 256 coordinates → every `cell_val` = 0; `num_flags` = 0; `num_open` = 0.
- At (3,5): `flag` → `cell_val` = 1, `num_flags` = 1. A second `flag` → `cell_val` = 0, `num_flags` = 0.
- At (3,5): `flag`, then `open` → stays 1. Then `flag`, then `open` → `cell_val` = 2, `num_open` = 1. A further `flag` → stays 2.
- `flag` and `open` together at (0,0) → `cell_val` = 0 and counters unchanged.
- Open (15,15), flag (0,15), then assert `reset` with `open` high at (1,1) → all cells 0, counters 0. Cell (1,1) stays 0.
- Move cursor (0,0) → (7,7) with no strobe → `cell_val` changes in the same cycle. Cell (7,7) is unaffected by earlier actions at (0,0).
